// File: rtl/hash_update_pkg.sv
// Shared constants and types for the SHA-256 chaining-state update stage.
// Build option: define SHA224_EN to select the SHA-224 IV and a 7-word digest.
package sha256_pkg;

    localparam int WORD_W     = 32;
    localparam int HASH_WORDS = 8;
    localparam int ADDR_W     = 3;

`ifdef SHA224_EN
    localparam bit USE_SHA224 = 1'b1;
`else
    localparam bit USE_SHA224 = 1'b0;
`endif

    // Word 0 (H0) sits in the least significant slot.
    localparam logic [HASH_WORDS-1:0][WORD_W-1:0] SHA256_IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    localparam logic [HASH_WORDS-1:0][WORD_W-1:0] SHA224_IV = {
        32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
        32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8
    };

    localparam logic [HASH_WORDS-1:0][WORD_W-1:0] ACTIVE_IV =
        USE_SHA224 ? SHA224_IV : SHA256_IV;

    // Index of the final digest word handed to the store stage.
    localparam logic [ADDR_W-1:0] EMIT_LAST = USE_SHA224 ? 3'd6 : 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } hash_upd_state_t;

    // Modulo-2^32 word addition; the carry out is dropped on purpose.
    function automatic logic [WORD_W-1:0] word_add(
        input logic [WORD_W-1:0] a,
        input logic [WORD_W-1:0] b
    );
        return a + b;
    endfunction

endpackage

// File: rtl/hash_update_if.sv
// Bundle of the upstream (round engine) and downstream (store_hash) signals
// of the hash update stage. master = the side driving the stage, slave = the stage.
interface hash_update_if;
    import sha256_pkg::*;

    logic                                 start_msg;
    logic                                 compress_done;
    logic                                 last_block;
    logic [HASH_WORDS*WORD_W-1:0]         working_vector;
    logic                                 block_ready;
    logic                                 store_enable;
    logic [ADDR_W-1:0]                    h_address;
    logic                                 address_read_complete;
    logic [HASH_WORDS*WORD_W-1:0]         hash_vector;
    logic                                 hash_valid;
    logic                                 overrun;

    modport master (
        output start_msg, compress_done, last_block, working_vector,
        input  block_ready, store_enable, h_address, address_read_complete,
               hash_vector, hash_valid, overrun
    );

    modport slave (
        input  start_msg, compress_done, last_block, working_vector,
        output block_ready, store_enable, h_address, address_read_complete,
               hash_vector, hash_valid, overrun
    );

endinterface

// File: rtl/hash_update_word_mux_add.sv
// Picks chaining word H[sel] and working word W[sel] and returns their
// 32-bit modular sum. Purely combinational.
module hash_word_mux_add
    import sha256_pkg::*;
(
    input  logic [HASH_WORDS-1:0][WORD_W-1:0] h_words,
    input  logic [HASH_WORDS-1:0][WORD_W-1:0] w_words,
    input  logic [ADDR_W-1:0]                 sel,
    output logic [WORD_W-1:0]                 sum
);

    // Select the addressed word pair and add them.
    always_comb begin
        sum = word_add(h_words[sel], w_words[sel]);
    end

endmodule

// File: rtl/hash_update.sv
// SHA-256 chaining-state update: folds each compression result into H0..H7
// one word per cycle, then walks the digest word index to the store stage.
// Build option: define SHA224_EN for the SHA-224 IV and a 7-word emit.
module hash_update
    import sha256_pkg::*;
#(
    parameter int HASH_LENGTH = 8
)
(
    input  logic          clock,
    input  logic          reset,
    hash_update_if.slave  bus
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_ADD  = ADD;
    localparam logic [1:0] S_EMIT = EMIT;
    localparam logic [1:0] S_DONE = DONE;

    localparam logic [ADDR_W-1:0] ADD_LAST = ADDR_W'(HASH_LENGTH - 1);
    localparam logic [ADDR_W-1:0] CNT_ZERO = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

    logic [1:0]                          state_r;
    logic [1:0]                          state_s;
    logic [ADDR_W-1:0]                   cnt_r;
    logic [ADDR_W-1:0]                   cnt_s;
    logic [HASH_WORDS-1:0][WORD_W-1:0]   h_r;
    logic [HASH_WORDS-1:0][WORD_W-1:0]   w_r;
    logic                                l_r;
    logic [WORD_W-1:0]                   sum_s;

    logic                                block_ready_r;
    logic                                store_enable_r;
    logic [ADDR_W-1:0]                   h_address_r;
    logic                                arc_r;
    logic                                hash_valid_r;
    logic                                overrun_r;

    hash_word_mux_add u_mux_add (
        .h_words (h_r),
        .w_words (w_r),
        .sel     (cnt_r),
        .sum     (sum_s)
    );

    // Next state and shared word counter (add index in ADD, digest index in EMIT/DONE).
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (bus.compress_done) begin
                    state_s = S_ADD;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ADD: begin
                if (cnt_r == ADD_LAST) begin
                    cnt_s   = CNT_ZERO;
                    state_s = l_r ? S_EMIT : S_IDLE;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            S_EMIT: begin
                if (cnt_r == EMIT_LAST) begin
                    state_s = S_DONE;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            S_DONE: begin
                if (bus.start_msg) begin
                    state_s = S_IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= S_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Chaining state: IV reload on start_msg, one modular add per ADD cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            h_r <= ACTIVE_IV;
        end else begin
            case (state_r)
                S_IDLE:  if (bus.start_msg) h_r <= ACTIVE_IV;
                S_ADD:   h_r[cnt_r] <= sum_s;
                S_DONE:  if (bus.start_msg) h_r <= ACTIVE_IV;
                default: h_r <= h_r;
            endcase
        end
    end

    // Capture the working variables and last-block flag only when a block is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_r <= '0;
            l_r <= 1'b0;
        end else if ((state_r == S_IDLE) && bus.compress_done) begin
            w_r <= bus.working_vector;
            l_r <= bus.last_block;
        end
    end

    // Sticky overrun: a block offered while busy is dropped and flagged until the next message.
    always_ff @(posedge clock) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else if ((state_r != S_IDLE) && bus.compress_done) begin
            overrun_r <= 1'b1;
        end else if (bus.start_msg && ((state_r == S_IDLE) || (state_r == S_DONE))) begin
            overrun_r <= 1'b0;
        end
    end

    // Output registers decoded from the next state so they line up with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            block_ready_r  <= 1'b1;
            store_enable_r <= 1'b0;
            h_address_r    <= CNT_ZERO;
            arc_r          <= 1'b0;
            hash_valid_r   <= 1'b0;
        end else begin
            block_ready_r  <= (state_s == S_IDLE);
            store_enable_r <= (state_s == S_EMIT) || (state_s == S_DONE);
            h_address_r    <= ((state_s == S_EMIT) || (state_s == S_DONE)) ? cnt_s : CNT_ZERO;
            arc_r          <= (state_s == S_EMIT) && (cnt_s == EMIT_LAST);
            hash_valid_r   <= (state_s == S_DONE);
        end
    end

    assign bus.block_ready           = block_ready_r;
    assign bus.store_enable          = store_enable_r;
    assign bus.h_address             = h_address_r;
    assign bus.address_read_complete = arc_r;
    assign bus.hash_vector           = h_r;
    assign bus.hash_valid            = hash_valid_r;
    assign bus.overrun               = overrun_r;

endmodule
